// File: rtl/fc_mac_seq_if.sv
// Stream bundle for the sequential FC neuron: input beats, bias, flush, result port and status.
// The slave modport is the neuron's view; the master modport is the producer/consumer side.
interface fc_mac_seq_if #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int N_IN      = 84,
  parameter int CNT_W     = $clog2(N_IN)
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [OUT_WIDTH-1:0] in_data;
  logic signed [BIT_WIDTH-1:0] in_weight;
  logic                        in_last;
  logic signed [BIT_WIDTH-1:0] bias;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out;
  logic [CNT_W-1:0]            beat_count;
  logic                        err_last;

  modport slave (
    input  flush, in_valid, in_data, in_weight, in_last, bias, out_ready,
    output in_ready, out_valid, out, beat_count, err_last
  );

  modport master (
    output flush, in_valid, in_data, in_weight, in_last, bias, out_ready,
    input  in_ready, out_valid, out, beat_count, err_last
  );
endinterface

// File: rtl/fc_mac_seq.sv
// Time-multiplexed fully-connected neuron: one (activation, weight) beat per clock,
// bias folded in on beat 0, optional ReLU, result held on a valid/ready port.
module fc_mac_seq #(
  parameter  int BIT_WIDTH = 32,
  parameter  int OUT_WIDTH = 64,
  parameter  int N_IN      = 84,
  parameter  int RELU      = 0,
  localparam int CNT_W     = $clog2(N_IN)
) (
  input logic         clk,
  input logic         rst,
  fc_mac_seq_if.slave bus
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

  logic [0:0]                  state;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] out_q;
  logic [CNT_W-1:0]            beat_count;
  logic                        out_valid;
  logic                        err_last;

  logic signed [OUT_WIDTH-1:0] weight_ext;
  logic signed [OUT_WIDTH-1:0] bias_ext;
  logic signed [OUT_WIDTH-1:0] product;
  logic signed [OUT_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] result;
  logic                        accept;
  logic                        final_beat;

  // All arithmetic is kept at OUT_WIDTH so products and adds wrap exactly like the
  // combinational neuron this block replaces.
  assign weight_ext = OUT_WIDTH'(bus.in_weight);
  assign bias_ext   = OUT_WIDTH'(bus.bias);
  assign product    = bus.in_data * weight_ext;
  assign final_beat = (beat_count == LAST_BEAT);
  assign sum        = ((beat_count == '0) ? bias_ext : acc) + product;
  assign result     = ((RELU != 0) && sum[OUT_WIDTH-1]) ? '0 : sum;
  assign accept     = bus.in_valid && (state == ST_ACC);

  assign bus.in_ready   = (state == ST_ACC);
  assign bus.out_valid  = out_valid;
  assign bus.out        = out_q;
  assign bus.beat_count = beat_count;
  assign bus.err_last   = err_last;

  // Framing errors are only flagged; the vector length is always N_IN beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACC;
      acc        <= '0;
      out_q      <= '0;
      beat_count <= '0;
      out_valid  <= 1'b0;
      err_last   <= 1'b0;
    end else if (bus.flush) begin
      state      <= ST_ACC;
      acc        <= '0;
      beat_count <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (bus.in_last != final_beat) begin
              err_last <= 1'b1;
            end
            if (final_beat) begin
              out_q      <= result;
              out_valid  <= 1'b1;
              acc        <= '0;
              beat_count <= '0;
              state      <= ST_HOLD;
            end else begin
              acc        <= sum;
              beat_count <= beat_count + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state     <= ST_ACC;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule
